// File: rtl/fdiv_round_if.sv
// Handshake and data bundle between the divider core, the round/pack stage
// and its consumer.
interface fdiv_round_if #(
    parameter int QW = 27,
    parameter int EW = 10
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic          sign_i;
    logic [EW-1:0] exp_i;
    logic [QW-1:0] q_i;
    logic          sticky_i;
    logic          a_zero_i;
    logic          a_inf_i;
    logic          a_nan_i;
    logic          b_zero_i;
    logic          b_inf_i;
    logic          b_nan_i;
    logic [1:0]    rm_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [31:0]   result_o;
    logic [4:0]    flags_o;

    // Round/pack stage side.
    modport slave (
        input  in_valid_i, sign_i, exp_i, q_i, sticky_i,
               a_zero_i, a_inf_i, a_nan_i, b_zero_i, b_inf_i, b_nan_i,
               rm_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, flags_o
    );

    // Producer/consumer side.
    modport master (
        output in_valid_i, sign_i, exp_i, q_i, sticky_i,
               a_zero_i, a_inf_i, a_nan_i, b_zero_i, b_inf_i, b_nan_i,
               rm_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, flags_o
    );
endinterface

// File: rtl/fdiv_round.sv
// Single-precision divider post-processing: normalise the raw quotient,
// round in the selected mode, resolve overflow/underflow/special operands
// and pack a binary32 result with {NV, DZ, OF, UF, NX}. Two stages with
// valid/ready flow control on both sides.
module fdiv_round #(
    parameter int QW = 27,
    parameter int EW = 10
) (
    input logic         clk_i,
    input logic         rst_ni,
    fdiv_round_if.slave bus
);
    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rm_e;

    localparam logic signed [EW:0] E_ONE  = (EW+1)'(1);
    localparam logic signed [EW:0] E_ZERO = '0;
    localparam logic signed [EW:0] E_MAX  = (EW+1)'(255);

    // Stage 1: normalised operand state.
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q,  s1_sign_d;
    logic [1:0]           s1_rm_q,    s1_rm_d;
    logic [5:0]           s1_cls_q,   s1_cls_d;   // {a_zero, a_inf, a_nan, b_zero, b_inf, b_nan}
    logic [23:0]          s1_m_q,     s1_m_d;
    logic                 s1_g_q,     s1_g_d;
    logic                 s1_s_q,     s1_s_d;
    logic signed [EW:0]   s1_e_q,     s1_e_d;

    // Stage 2: packed result.
    logic                 s2_valid_q,  s2_valid_d;
    logic [31:0]          s2_result_q, s2_result_d;
    logic [4:0]           s2_flags_q,  s2_flags_d;

    logic s2_adv, s1_adv;

    // Per-stage advance: a stage moves when it is empty or its successor moves.
    assign s2_adv = !s2_valid_q || bus.out_ready_i;
    assign s1_adv = !s1_valid_q || s2_adv;

    assign bus.in_ready_o  = s1_adv;
    assign bus.out_valid_o = s2_valid_q;
    assign bus.result_o    = s2_result_q;
    assign bus.flags_o     = s2_flags_q;

    // Stage 1 next state: pick the leading-one window of the quotient.
    always_comb begin
        // NOTE: every output gets a hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_rm_d    = s1_rm_q;
        s1_cls_d   = s1_cls_q;
        s1_m_d     = s1_m_q;
        s1_g_d     = s1_g_q;
        s1_s_d     = s1_s_q;
        s1_e_d     = s1_e_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_sign_d = bus.sign_i;
                s1_rm_d   = bus.rm_i;
                s1_cls_d  = {bus.a_zero_i, bus.a_inf_i, bus.a_nan_i,
                             bus.b_zero_i, bus.b_inf_i, bus.b_nan_i};
                if (bus.q_i[QW-1]) begin
                    s1_m_d = bus.q_i[QW-1 -: 24];
                    s1_g_d = bus.q_i[QW-25];
                    s1_s_d = (|bus.q_i[QW-26:0]) | bus.sticky_i;
                    s1_e_d = {bus.exp_i[EW-1], bus.exp_i};
                end else begin
                    s1_m_d = bus.q_i[QW-2 -: 24];
                    s1_g_d = bus.q_i[QW-26];
                    s1_s_d = (|bus.q_i[QW-27:0]) | bus.sticky_i;
                    s1_e_d = {bus.exp_i[EW-1], bus.exp_i} - E_ONE;
                end
            end
        end
    end

    logic               inc;
    logic [24:0]        m_sum;
    logic [23:0]        m_rnd;
    logic signed [EW:0] e_rnd;
    logic               to_inf;
    logic [31:0]        res;
    logic [4:0]         flg;

    // Stage 2 next state: round, range-check, then let specials override.
    always_comb begin
        inc = 1'b0;
        unique case (rm_e'(s1_rm_q))
            RM_RNE:  inc = s1_g_q & (s1_s_q | s1_m_q[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = (s1_g_q | s1_s_q) & !s1_sign_q;
            RM_RDN:  inc = (s1_g_q | s1_s_q) &  s1_sign_q;
            default: inc = 1'b0;
        endcase
        m_sum = {1'b0, s1_m_q} + {24'd0, inc};
        m_rnd = m_sum[23:0];
        e_rnd = s1_e_q;
        if (m_sum[24]) begin
            m_rnd = m_sum[24:1];
            e_rnd = s1_e_q + E_ONE;
        end

        res    = {s1_sign_q, e_rnd[7:0], m_rnd[22:0]};
        flg    = {4'b0000, s1_g_q | s1_s_q};
        to_inf = (rm_e'(s1_rm_q) == RM_RNE)
              || (rm_e'(s1_rm_q) == RM_RUP && !s1_sign_q)
              || (rm_e'(s1_rm_q) == RM_RDN &&  s1_sign_q);
        if (e_rnd >= E_MAX) begin
            res = to_inf ? {s1_sign_q, 8'hFF, 23'd0} : {s1_sign_q, 31'h7F7F_FFFF};
            flg = 5'b00101;
        end else if (e_rnd <= E_ZERO) begin
            res = {s1_sign_q, 31'd0};
            flg = 5'b00011;
        end

        // Operand classes, highest priority first.
        if (s1_cls_q[3] || s1_cls_q[0] || (s1_cls_q[5] && s1_cls_q[2])
                || (s1_cls_q[4] && s1_cls_q[1])) begin
            res = 32'h7FC0_0000;
            flg = {(s1_cls_q[5] && s1_cls_q[2]) || (s1_cls_q[4] && s1_cls_q[1]), 4'b0000};
        end else if (s1_cls_q[4]) begin
            res = {s1_sign_q, 8'hFF, 23'd0};
            flg = 5'b00000;
        end else if (s1_cls_q[2]) begin
            res = {s1_sign_q, 8'hFF, 23'd0};
            flg = 5'b01000;
        end else if (s1_cls_q[1] || s1_cls_q[5]) begin
            res = {s1_sign_q, 31'd0};
            flg = 5'b00000;
        end

        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = res;
                s2_flags_d  = flg;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: datapath registers are reset too, because result_o and
        // flags_o must read zero while reset is held, not just the valids.
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_rm_q     <= 2'b00;
            s1_cls_q    <= '0;
            s1_m_q      <= '0;
            s1_g_q      <= 1'b0;
            s1_s_q      <= 1'b0;
            s1_e_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_rm_q     <= s1_rm_d;
            s1_cls_q    <= s1_cls_d;
            s1_m_q      <= s1_m_d;
            s1_g_q      <= s1_g_d;
            s1_s_q      <= s1_s_d;
            s1_e_q      <= s1_e_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end
endmodule

// File: doc/fdiv_round.md
Name: fdiv_round

Overview:
- Downstream post-processing stage for the single-precision divider.
- Takes the divider's raw sign, pre-normalisation biased exponent, 27-bit fixed-point quotient, sticky bit and operand class flags.
- Normalises, rounds per the selected IEEE-754 mode, applies overflow/underflow/special-case rules, and emits a packed binary32 result with exception flags.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- QW, 27, quotient width; q_i = floor((ma<<26)/mb) with ma, mb normalised 24-bit mantissas.
- EW, 10, width of signed biased exponent input.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  stage can accept input
- sign_i  in  1  result sign (a_sign ^ b_sign)
- exp_i  in  EW  signed biased exponent, ea - eb + 127
- q_i  in  QW  raw quotient, q_i[26] or q_i[25] is set for finite non-zero operands
- sticky_i  in  1  division remainder non-zero
- a_zero_i, a_inf_i, a_nan_i  in  1 each  operand A class
- b_zero_i, b_inf_i, b_nan_i  in  1 each  operand B class
- rm_i  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- result_o  out  32  binary32 result
- flags_o  out  5  {NV, DZ, OF, UF, NX}

Behaviour:
- Reset (async, rst_ni low): both stage valids 0; out_valid_o=0; result_o=0; flags_o=0. Any beat in flight is discarded; no output after reset release until a new input is accepted.
- Advance rule:
  - s2_adv = !s2_valid | out_ready_i
  - s1_adv = !s1_valid | s2_adv
  - in_ready_o = s1_adv (combinational from out_ready_i)
  - Input is accepted on in_valid_i & in_ready_o.
- Latency: 2 cycles from accept to out_valid_o with no backpressure; throughput 1 per cycle.
- While out_valid_o & !out_ready_i, result_o and flags_o hold stable, and the pipeline stalls with no beat lost or duplicated.
- Stage 1 (normalise), registers sign, rm, class flags and:
  - If q[26]=1: M=q[26:3], G=q[2], S=q[1]|q[0]|sticky_i, E=exp_i.
  - Else: M=q[25:2], G=q[1], S=q[0]|sticky_i, E=exp_i-1.
  - E is computed at EW+1 bits signed; no wrap.
- Stage 2 (round and pack):
  - Increment condition:
    - RNE: G&(S|M[0])
    - RTZ: never
    - RUP: (G|S)&!sign
    - RDN: (G|S)&sign
  - M'=M+inc at 25 bits. If M'[24], then M'=M'>>1 and E=E+1.
  - NX=G|S for finite results.
  - E>=255 (overflow): OF=1, NX=1.
    - Result is ±inf if (RNE) or (RUP & +) or (RDN & -).
    - Otherwise it is ±max finite, 0x7F7FFFFF with the sign applied.
  - E<=0 (underflow): flush to signed zero; UF=1, NX=1. No denormal output.
  - Normal result = {sign, E[7:0], M'[22:0]}.
- Special priority, highest first; each overrides the arithmetic path:
  1. a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf): result 0x7FC00000. NV=1 only for 0/0 or inf/inf.
  2. a_inf: signed inf, no flags.
  3. b_zero: signed inf, DZ=1.
  4. b_inf | a_zero: signed zero, no flags.
- Specials ignore q_i, exp_i and sticky_i.
- Flags are per-result and not sticky across beats.

Test Plan:
- 6.0/3.0: q_i=0x4000000, exp_i=128, sticky_i=0, RNE -> result_o=0x40000000, flags=0, valid exactly 2 cycles after accept.
- 1.0/3.0: q_i=0x2AAAAAA, exp_i=126, sticky_i=1, RNE -> 0x3EAAAAAB, NX=1. Same inputs with RTZ -> 0x3EAAAAAA, NX=1.
- Overflow: q_i=0x4000000, exp_i=300, sign 0. RNE -> 0x7F800000, OF|NX. RTZ -> 0x7F7FFFFF. Sign 1 with RUP -> 0xFF7FFFFF.
- Underflow and specials:
  - exp_i=0, q_i=0x4000000 -> 0x00000000, UF|NX.
  - b_zero with finite a, sign 1 -> 0xFF800000, DZ.
  - 0/0 -> 0x7FC00000, NV.
- Backpressure: stream 4 beats with in_valid_i held high; hold out_ready_i low for 3 cycles after the first out_valid_o. Required: in_ready_o drops once both stages are full, result_o stays stable, and all 4 results appear in order with none lost or duplicated.
- Reset mid-operation: assert rst_ni low with 2 beats in flight. Required: out_valid_o=0, result_o=0, flags_o=0 immediately (async). After release, no stale output appears; the next accepted beat emerges 2 cycles later.
